i2c_slave: RTL and testbench



---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_sync.sv | 89 ++++++++
 rtl/i2c_slave.sv | 187 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state codes and bus-level constants.
package i2c_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] RX       = 3'd3;
    localparam logic [2:0] RX_ACK   = 3'd4;
    localparam logic [2:0] TX       = 3'd5;
    localparam logic [2:0] TX_ACK   = 3'd6;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic ACK   = 1'b0;
    localparam logic NACK  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser and bus-event detector (SCL edges, START, STOP).
// Optional 3-sample stability filter enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d;
    logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

    always_comb begin
        scl_meta_d = scl_in;
        scl_sync_d = scl_meta_q;
        sda_meta_d = sda_in;
        sda_sync_d = sda_meta_q;
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Everything resets to the idle-bus level so no false edge appears at reset release.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    // Output follows the input only once three consecutive samples agree.
    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q};
        sda_hist_d = {sda_hist_q[0], sda_sync_q};
        scl_filt_d = scl_filt_q;
        sda_filt_d = sda_filt_q;
        if (scl_hist_q == {2{scl_sync_q}}) scl_filt_d = scl_sync_q;
        if (sda_hist_q == {2{sda_sync_q}}) sda_filt_d = sda_sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_sync_q;
    assign sda_s = sda_sync_q;
`endif

    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with 7-bit addressing and byte-level rx/tx handshake to local logic.
// Build option: I2C_SLAVE_GLITCH_FILTER_EN adds an input stability filter in i2c_line_sync.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [2:0] state,
    output logic       busy
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
    logic       rw_q, rw_d, sda_out_q, sda_out_d, rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d, busy_q, busy_d;
    logic       addr_match;

    assign addr_match = (shift_q[7:1] == SLAVE_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // START outranks STOP, which outranks any SCL edge seen in the same clk.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (scl_fall && bit_cnt_q == 4'd8) state_d = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK: if (scl_fall) state_d = (rw_q == READ) ? TX : RX;
                RX:       if (scl_fall && bit_cnt_q == 4'd8) state_d = RX_ACK;
                RX_ACK:   if (scl_fall) state_d = RX;
                TX:       if (scl_fall && bit_cnt_q == 4'd8) state_d = TX_ACK;
                TX_ACK: begin
                    if (scl_rise && sda_s == NACK) state_d = IDLE;
                    else if (scl_fall)             state_d = TX;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        sda_out_d  = sda_out_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (start_det) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
        end else if (stop_det) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, RX: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == RX && bit_cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == RX) begin
                            sda_out_d = ACK;
                        end else if (addr_match) begin
                            sda_out_d = ACK;
                            busy_d    = 1'b1;
                            rw_d      = shift_q[0];
                        end else begin
                            busy_d    = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise && rw_q == READ) tx_req_d = 1'b1;
                    if (scl_fall) begin
                        if (rw_q == READ) begin
                            tx_shift_d = tx_data;
                            sda_out_d  = tx_data[7];
                            bit_cnt_d  = 4'd1;
                        end else begin
                            sda_out_d  = 1'b1;
                            bit_cnt_d  = 4'd0;
                        end
                    end
                end
                RX_ACK: if (scl_fall) sda_out_d = 1'b1;
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = 4'd0;
                        end else begin
                            sda_out_d  = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == ACK) tx_req_d = 1'b1;
                        else              busy_d   = 1'b0;
                    end else if (scl_fall) begin
                        tx_shift_d = tx_data;
                        sda_out_d  = tx_data[7];
                        bit_cnt_d  = 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rw_q       <= WRITE;
            sda_out_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            sda_out_q  <= sda_out_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_out  = sda_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign state    = state_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master on an open-drain SDA, immediate-assertion checks.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_out, rx_valid, tx_req, busy, sda_line;
    logic [7:0] rx_data;
    logic [2:0] state;

    assign sda_line = m_sda & sda_out;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h55)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_out  (sda_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .state    (state),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int txreq_cnt = 0;
    int sda_low_cnt = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_q.push_back(rx_data);
        end
        if (tx_req) txreq_cnt++;
        if (!sda_out) sda_low_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic seen);
        m_sda = b;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(5);
        seen = sda_line;
        wait_clk(5);
        scl = 1'b0;
        wait_clk(6);
    endtask

    task automatic bit_glitch(input logic b);
        m_sda = b;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(1);
        scl = 1'b1;
        wait_clk(6);
        scl = 1'b0;
        wait_clk(6);
    endtask

    task automatic start_cond();
        m_sda = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        m_sda = 1'b0;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(6);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        m_sda = 1'b1;
        wait_clk(6);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], dummy);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(master_ack, dummy);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rx0, tr0, sl0;

        // Reset values
        wait_clk(3);
        check("reset_sda_out", sda_out, 1'b1);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_tx_req", tx_req, 1'b0);
        check("reset_state", state, 3'd0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        wait_clk(4);

        // Write 0x55+W, 0xA5, 0x3C, STOP
        rx0 = rx_cnt;
        start_cond();
        check("wr_state_addr", state, 3'd1);
        write_byte(8'hAA, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", busy, 1'b1);
        check("wr_state_rx", state, 3'd3);
        write_byte(8'hA5, ack);
        check("wr_d0_ack", ack, 1'b0);
        write_byte(8'h3C, ack);
        check("wr_d1_ack", ack, 1'b0);
        stop_cond();
        check("wr_rx_count", rx_cnt - rx0, 2);
        check("wr_rx_byte0", rx_q[rx0], 8'hA5);
        check("wr_rx_byte1", rx_q[rx0 + 1], 8'h3C);
        check("wr_rx_data", rx_data, 8'h3C);
        check("wr_state_idle", state, 3'd0);
        check("wr_busy_end", busy, 1'b0);

        // Write to a foreign address 0x2A+W: never acknowledged
        rx0 = rx_cnt;
        sl0 = sda_low_cnt;
        start_cond();
        write_byte(8'h54, ack);
        check("nack_addr_ack", ack, 1'b1);
        check("nack_state", state, 3'd0);
        write_byte(8'hFF, ack);
        check("nack_data_ack", ack, 1'b1);
        check("nack_state_held", state, 3'd0);
        stop_cond();
        check("nack_sda_never_low", sda_low_cnt - sl0, 0);
        check("nack_no_rx", rx_cnt - rx0, 0);
        check("nack_busy", busy, 1'b0);

        // General call 0x00+W is ignored for a non-zero address
        start_cond();
        write_byte(8'h00, ack);
        check("gencall_ack", ack, 1'b1);
        stop_cond();

        // Read 0x55+R: 0x96 ACKed, then 0x0F NACKed
        tr0 = txreq_cnt;
        tx_data = 8'h96;
        start_cond();
        write_byte(8'hAB, ack);
        check("rd_addr_ack", ack, 1'b0);
        check("rd_txreq_first", txreq_cnt - tr0, 1);
        check("rd_state_tx", state, 3'd5);
        tx_data = 8'h0F;
        read_byte(1'b0, rd);
        check("rd_byte0", rd, 8'h96);
        check("rd_txreq_second", txreq_cnt - tr0, 2);
        tx_data = 8'hC3;
        read_byte(1'b1, rd);
        check("rd_byte1", rd, 8'h0F);
        check("rd_state_idle", state, 3'd0);
        check("rd_busy_end", busy, 1'b0);
        check("rd_txreq_total", txreq_cnt - tr0, 2);
        stop_cond();

        // Repeated START after 4 data bits of a write, then read 0x5A
        rx0 = rx_cnt;
        tx_data = 8'h5A;
        start_cond();
        write_byte(8'hAA, ack);
        check("rs_addr_ack", ack, 1'b0);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b0, ack);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b1, ack);
        start_cond();
        check("rs_state_addr", state, 3'd1);
        write_byte(8'hAB, ack);
        check("rs_raddr_ack", ack, 1'b0);
        read_byte(1'b1, rd);
        check("rs_read_byte", rd, 8'h5A);
        check("rs_no_rx", rx_cnt - rx0, 0);
        check("rs_state_idle", state, 3'd0);
        stop_cond();

        // Asynchronous reset while driving a 0 data bit
        tx_data = 8'h00;
        start_cond();
        write_byte(8'hAB, ack);
        check("rst_pre_sda_low", sda_out, 1'b0);
        check("rst_pre_state", state, 3'd5);
        #3 rst = 1'b1;
        #1;
        check("rst_async_sda", sda_out, 1'b1);
        check("rst_async_state", state, 3'd0);
        check("rst_async_busy", busy, 1'b0);
        wait_clk(2);
        rst = 1'b0;
        stop_cond();
        check("rst_after_state", state, 3'd0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // A 1-clk SCL low pulse inside a data bit must not disturb the byte
        rx0 = rx_cnt;
        start_cond();
        write_byte(8'hAA, ack);
        check("gf_addr_ack", ack, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) bit_glitch(1'b0);
            else        bit_xfer(((8'h69 >> i) & 8'h01) != 8'h00, rd[0]);
        end
        bit_xfer(1'b1, ack);
        check("gf_data_ack", ack, 1'b0);
        check("gf_rx_count", rx_cnt - rx0, 1);
        check("gf_rx_data", rx_data, 8'h69);
        stop_cond();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
